// File: rtl/numeros_pkg.sv
// Shared definitions for the ASCII decimal number assembler.
// The state encoding is one-hot so it matches the binary-to-ASCII sender.
package numeros_pkg;

    typedef enum logic [2:0] {
        STATE_IDLE    = 3'b001,
        STATE_ACCUM   = 3'b010,
        STATE_DISCARD = 3'b100
    } state_e;

    localparam logic [7:0] ASCII_ZERO         = 8'h30;
    localparam logic [7:0] ASCII_NINE         = 8'h39;
    localparam logic [7:0] DEFAULT_TERMINATOR = 8'h0D;

    localparam int VALUE_W = 32;
    localparam int ACC_W   = 36;
    localparam int COUNT_W = 4;

    // acc*10 + digit without a multiplier. 36 bits cannot wrap while acc holds a 32-bit value.
    function automatic logic [ACC_W-1:0] times_ten_plus(input logic [ACC_W-1:0] acc,
                                                        input logic [3:0]       digit);
        return (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, digit};
    endfunction

endpackage

// File: rtl/digito_ascii.sv
// Combinational classifier for one received byte.
// Reports decimal digit / terminator and the digit's binary value.
module digito_ascii
    import numeros_pkg::*;
#(
    parameter logic [7:0] TERMINATOR = DEFAULT_TERMINATOR
) (
    input  logic [7:0] byte_i,
    output logic       is_digit_o,
    output logic       is_term_o,
    output logic [3:0] digit_o
);

    assign is_digit_o = (byte_i >= ASCII_ZERO) && (byte_i <= ASCII_NINE);
    assign is_term_o  = (byte_i == TERMINATOR);

    // '0'..'9' are 0x30..0x39, so the low nibble already is the digit value.
    assign digit_o = byte_i[3:0];

endmodule

// File: rtl/ensamblador_numeros.sv
// Assembles ASCII decimal digits from the UART receiver into a 32-bit value.
// Numbers end at TERMINATOR; over-long, overflowing or malformed numbers raise error.
module ensamblador_numeros
    import numeros_pkg::*;
#(
    parameter int         MAX_DIGITS = 10,
    parameter logic [7:0] TERMINATOR = DEFAULT_TERMINATOR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_done,
    output logic [VALUE_W-1:0]  value_out,
    output logic                value_valid,
    output logic                error,
    output logic                busy
);

    localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_DIGITS);

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    acc_next;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic [VALUE_W-1:0]  value_q, value_d;
    logic                valid_q, valid_d;
    logic                error_q, error_d;
    logic                busy_q, busy_d;

    logic                is_digit;
    logic                is_term;
    logic [3:0]          digit;
    logic                overflow;
    logic                too_long;

    digito_ascii #(
        .TERMINATOR (TERMINATOR)
    ) u_clasificador (
        .byte_i     (rx_data),
        .is_digit_o (is_digit),
        .is_term_o  (is_term),
        .digit_o    (digit)
    );

    assign acc_next = times_ten_plus(acc_q, digit);
    assign overflow = |acc_next[ACC_W-1:VALUE_W];
    assign too_long = (count_q == MAX_COUNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STATE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            count_q <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            value_q <= value_d;
            valid_q <= valid_d;
            error_q <= error_d;
            busy_q  <= busy_d;
        end
    end

    // The terminator is tested before the digit range so a digit-valued terminator still ends numbers.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        if (rx_done) begin
            case (state_q)
                STATE_IDLE: begin
                    if (is_term) begin
                        state_d = STATE_IDLE;
                    end else if (is_digit) begin
                        acc_d   = {{(ACC_W-4){1'b0}}, digit};
                        count_d = COUNT_W'(1);
                        state_d = STATE_ACCUM;
                    end else begin
                        state_d = STATE_DISCARD;
                    end
                end
                STATE_ACCUM: begin
                    if (is_term) begin
                        state_d = STATE_IDLE;
                    end else if (is_digit) begin
                        if (too_long || overflow) begin
                            state_d = STATE_DISCARD;
                        end else begin
                            acc_d   = acc_next;
                            count_d = count_q + COUNT_W'(1);
                        end
                    end else begin
                        state_d = STATE_DISCARD;
                    end
                end
                STATE_DISCARD: begin
                    if (is_term) begin
                        state_d = STATE_IDLE;
                    end
                end
                default: begin
                    state_d = STATE_IDLE;
                end
            endcase
        end
    end

    // Pulses default low every cycle, so each lasts exactly one cycle after the terminator edge.
    always_comb begin
        value_d = value_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        busy_d  = (state_d != STATE_IDLE);
        if (rx_done && is_term) begin
            if (state_q == STATE_ACCUM) begin
                value_d = acc_q[VALUE_W-1:0];
                valid_d = 1'b1;
            end else if (state_q == STATE_DISCARD) begin
                error_d = 1'b1;
            end
        end
    end

    assign value_out   = value_q;
    assign value_valid = valid_q;
    assign error       = error_q;
    assign busy        = busy_q;

endmodule
